// File: rtl/uart_mem_loader.sv
// UART 8N1 image loader: receives a length-prefixed word stream and writes it into
// data memory while holding the CPU in reset until the last word has landed.
module uart_mem_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter logic [15:0] MAX_WORDS    = 16'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        Ext_MemWrite,
    output logic [31:0] Ext_WriteData,
    output logic [31:0] Ext_DataAdr,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        frame_err,
    output logic [15:0] word_count
);

    localparam int              CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {LD_HDR0, LD_HDR1, LD_DATA, LD_WRITE, LD_DONE} ld_state_t;

    rx_state_t      rx_state;
    ld_state_t      ld_state;
    logic           rx_meta;
    logic           rx_sync;
    logic [CW-1:0]  rx_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     rx_shift;
    logic           byte_valid;
    logic [15:0]    word_total;
    logic [15:0]    hdr_count;
    logic [15:0]    hdr_clamped;
    logic [23:0]    assemble;
    logic [1:0]     byte_idx;
    logic [15:0]    next_count;

    // Synchronizer idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments here keep the two flops a true 2-stage chain.
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // NOTE: default-low here makes byte_valid a single-cycle pulse.
            byte_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) byte_valid <= 1'b1;
                        else         frame_err  <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_comb begin
        hdr_count   = {rx_shift, word_total[7:0]};
        hdr_clamped = (hdr_count > MAX_WORDS) ? MAX_WORDS : hdr_count;
        next_count  = word_count + 16'd1;
    end

    // Strobe is issued one cycle after the 4th byte; address/count advance in LD_WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_state      <= LD_HDR0;
            word_total    <= '0;
            assemble      <= '0;
            byte_idx      <= '0;
            Ext_MemWrite  <= 1'b0;
            Ext_WriteData <= '0;
            Ext_DataAdr   <= BASE_ADDR;
            word_count    <= '0;
            cpu_reset     <= 1'b1;
        end else begin
            Ext_MemWrite <= 1'b0;
            case (ld_state)
                LD_HDR0: begin
                    if (byte_valid) begin
                        word_total[7:0] <= rx_shift;
                        ld_state        <= LD_HDR1;
                    end
                end
                LD_HDR1: begin
                    if (byte_valid) begin
                        word_total <= hdr_clamped;
                        byte_idx   <= '0;
                        if (hdr_clamped == 16'd0) begin
                            ld_state  <= LD_DONE;
                            cpu_reset <= 1'b0;
                        end else begin
                            ld_state <= LD_DATA;
                        end
                    end
                end
                LD_DATA: begin
                    if (byte_valid) begin
                        if (byte_idx == 2'd3) begin
                            Ext_WriteData <= {rx_shift, assemble};
                            Ext_MemWrite  <= 1'b1;
                            ld_state      <= LD_WRITE;
                        end else begin
                            assemble <= {rx_shift, assemble[23:8]};
                        end
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
                LD_WRITE: begin
                    Ext_DataAdr <= Ext_DataAdr + 32'd4;
                    word_count  <= next_count;
                    if (next_count == word_total) begin
                        ld_state  <= LD_DONE;
                        cpu_reset <= 1'b0;
                    end else begin
                        ld_state <= LD_DATA;
                    end
                end
                LD_DONE: ;
                default: ld_state <= LD_HDR0;
            endcase
        end
    end

    assign load_done = ~cpu_reset;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: serial frames driven on rx, write strobes
// logged by a negedge monitor and compared against hand-computed words.
module tb_uart_mem_loader;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        Ext_MemWrite;
    logic [31:0] Ext_WriteData;
    logic [31:0] Ext_DataAdr;
    logic        cpu_reset;
    logic        load_done;
    logic        frame_err;
    logic [15:0] word_count;

    int n_checks = 0;
    int n_fails  = 0;

    uart_mem_loader #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR   (32'h0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .Ext_MemWrite (Ext_MemWrite),
        .Ext_WriteData(Ext_WriteData),
        .Ext_DataAdr  (Ext_DataAdr),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .frame_err    (frame_err),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    // Monitor: logs strobes, byte_valid pulses and the cpu_reset falling edge.
    int          cyc = 0;
    int          n_strobes = 0;
    int          bv_count = 0;
    int          last_strobe_cyc = -1;
    int          last_bv_cyc = -1;
    int          fall_cyc = -1;
    int          run = 0;
    bit          wide_strobe = 1'b0;
    logic        prev_cpu_reset = 1'b1;
    logic [31:0] log_data [16];
    logic [31:0] log_addr [16];

    always @(negedge clk) begin
        cyc++;
        if (Ext_MemWrite === 1'b1) begin
            if (n_strobes < 16) begin
                log_data[n_strobes] = Ext_WriteData;
                log_addr[n_strobes] = Ext_DataAdr;
            end
            n_strobes++;
            last_strobe_cyc = cyc;
            run++;
            if (run > 1) wide_strobe = 1'b1;
        end else begin
            run = 0;
        end
        if (dut.byte_valid === 1'b1) begin
            bv_count++;
            last_bv_cyc = cyc;
        end
        if (prev_cpu_reset === 1'b1 && cpu_reset === 1'b0) fall_cyc = cyc;
        prev_cpu_reset = cpu_reset;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        rx = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " cpu_reset"},  32'(cpu_reset),    32'd1);
        check({tag, " memwrite"},   32'(Ext_MemWrite), 32'd0);
        check({tag, " wdata"},      Ext_WriteData,     32'h0);
        check({tag, " addr"},       Ext_DataAdr,       32'h0);
        check({tag, " load_done"},  32'(load_done),    32'd0);
        check({tag, " frame_err"},  32'(frame_err),    32'd0);
        check({tag, " word_count"}, 32'(word_count),   32'd0);
    endtask

    initial begin
        int base;
        int bv_base;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Short low glitch while idle must not start a byte
        bv_base = bv_count;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch byte_valid", 32'(bv_count - bv_base), 32'd0);
        check("glitch frame_err",  32'(frame_err),          32'd0);
        check("glitch cpu_reset",  32'(cpu_reset),          32'd1);

        // Two-word image
        base = n_strobes;
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        check("w0 cpu_reset held", 32'(cpu_reset), 32'd1);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hDE, 1'b1);
        check("img strobes",   32'(n_strobes - base), 32'd2);
        check("img w0 data",   log_data[base],        32'h12345678);
        check("img w0 addr",   log_addr[base],        32'h0);
        check("img w1 data",   log_data[base+1],      32'hDEADBEEF);
        check("img w1 addr",   log_addr[base+1],      32'h4);
        check("img count",     32'(word_count),       32'd2);
        check("img cpu_reset", 32'(cpu_reset),        32'd0);
        check("img load_done", 32'(load_done),        32'd1);
        check("img fall lag",  32'(fall_cyc - last_strobe_cyc), 32'd1);
        check("img next addr", Ext_DataAdr,           32'h8);
        check("img wdata hold", Ext_WriteData,        32'hDEADBEEF);

        // Bytes after DONE are ignored
        base = n_strobes;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        check("done strobes",   32'(n_strobes - base), 32'd0);
        check("done cpu_reset", 32'(cpu_reset),        32'd0);
        check("done count",     32'(word_count),       32'd2);

        // Zero-length header
        pulse_reset();
        base = n_strobes;
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check("zero strobes",   32'(n_strobes - base), 32'd0);
        check("zero cpu_reset", 32'(cpu_reset),        32'd0);
        check("zero load_done", 32'(load_done),        32'd1);
        check("zero fall lag",  32'(fall_cyc - last_bv_cyc), 32'd1);

        // Framing error during header drops the byte
        pulse_reset();
        bv_base = bv_count;
        base = n_strobes;
        send_byte(8'h55, 1'b0);
        check("ferr set",        32'(frame_err),          32'd1);
        check("ferr no byte",    32'(bv_count - bv_base), 32'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        check("ferr strobes",   32'(n_strobes - base), 32'd1);
        check("ferr w0 data",   log_data[base],        32'hDDCCBBAA);
        check("ferr w0 addr",   log_addr[base],        32'h0);
        check("ferr sticky",    32'(frame_err),        32'd1);
        check("ferr load_done", 32'(load_done),        32'd1);

        // Reset mid-word, then full resend
        pulse_reset();
        base = n_strobes;
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("midrst");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        check("resend strobes",   32'(n_strobes - base), 32'd1);
        check("resend w0 data",   log_data[base],        32'h44332211);
        check("resend w0 addr",   log_addr[base],        32'h0);
        check("resend count",     32'(word_count),       32'd1);
        check("resend cpu_reset", 32'(cpu_reset),        32'd0);

        check("strobe width", 32'(wide_strobe), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
